// File: rtl/lift_buf_pkg.sv
// Shared types and helpers for the lift ping-pong input buffer.
// Bank states, default geometry and the per-mode completeness mask.
package lift_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        BUSY  = 2'd2
    } bank_st_t;

    localparam int DEF_LANES = 8;
    localparam int DEF_CW    = 30;
    localparam int DEF_Q_CNT = 6;
    localparam int DEF_P_CNT = 7;
    localparam int DEF_AW    = 4;

    // Word-valid bits a batch must carry before it may be handed to the core.
    function automatic logic [31:0] req_mask(input logic mode, input int q_cnt, input int p_cnt);
        int n;
        n = mode ? p_cnt : q_cnt;
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/lift_buf_bank.sv
// One buffer bank: P_CNT packed residue words, word-valid mask, write port, registered read.
// Read latency 1 cycle (zero when not enabled); no backpressure, the controller gates writes.
module lift_buf_bank #(
    parameter int LANES = 8,
    parameter int CW    = 30,
    parameter int P_CNT = 7,
    parameter int AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [LANES*CW-1:0]   i_wdat,
    input  logic                  i_clr,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_raddr,
    output logic [LANES*CW-1:0]   o_rd_dat,
    output logic [P_CNT-1:0]      o_mask
);
    localparam int DW = LANES * CW;
    localparam logic [AW:0] P_LIM = (AW+1)'(P_CNT);

    logic [DW-1:0]    r_mem [P_CNT];
    logic [DW-1:0]    r_rd_dat;
    logic [P_CNT-1:0] r_mask;
    logic             w_raddr_ok;

    assign w_raddr_ok = ({1'b0, i_raddr} < P_LIM);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_dat <= '0;
            r_mask   <= '0;
        end else begin
            r_rd_dat <= (i_rd_en && w_raddr_ok) ? r_mem[i_raddr] : '0;
            if (i_clr) begin
                r_mask <= '0;
            end else if (i_we) begin
                r_mask <= r_mask | (P_CNT'(1) << i_waddr);
            end
        end
    end

    assign o_rd_dat = r_rd_dat;
    assign o_mask   = r_mask;

endmodule

// File: rtl/lift_pingpong_buf.sv
// Ping-pong host->lift-core buffer; core_dout 1-cycle latency, host stalled via ext_full, core via core_req/ack.
// Optional LIFT_BUF_CNT_EN adds batch_cnt / drop_cnt 16-bit wrapping counters.
module lift_pingpong_buf
    import lift_buf_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int CW    = DEF_CW,
    parameter int Q_CNT = DEF_Q_CNT,
    parameter int P_CNT = DEF_P_CNT,
    parameter int AW    = DEF_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [AW-1:0]         ext_addr,
    input  logic [LANES*CW-1:0]   ext_din,
    input  logic                  ext_we,
    input  logic                  ext_we_done,
    output logic                  ext_full,
    output logic                  core_req,
    output logic                  core_mode,
    input  logic                  core_ack,
    input  logic [AW-1:0]         core_addr,
    output logic [LANES*CW-1:0]   core_dout,
    input  logic                  core_done,
    output logic                  err_ovf,
    output logic                  err_len,
`ifdef LIFT_BUF_CNT_EN
    input  logic                  err_clr,
    output logic [15:0]           batch_cnt,
    output logic [15:0]           drop_cnt
`else
    input  logic                  err_clr
`endif
);
    localparam int DW = LANES * CW;
    localparam logic [AW:0]    P_LIM  = (AW+1)'(P_CNT);
    localparam logic [31:0]    MQ_W   = req_mask(1'b0, Q_CNT, P_CNT);
    localparam logic [31:0]    MP_W   = req_mask(1'b1, Q_CNT, P_CNT);
    localparam logic [P_CNT-1:0] MASK_Q = MQ_W[P_CNT-1:0];
    localparam logic [P_CNT-1:0] MASK_P = MP_W[P_CNT-1:0];

    bank_st_t [1:0] r_st;
    logic [1:0]     r_mode;
    logic           r_wb, r_rb;
    logic           r_err_ovf, r_err_len;

    logic [P_CNT-1:0] w_mask [2];
    logic [DW-1:0]    w_rd   [2];
    logic [P_CNT-1:0] w_mask_eff, w_need;
    logic w_full, w_any_busy, w_addr_ok, w_wr_ok;
    logic w_done_try, w_fill_ok, w_fill_bad, w_ack_ok, w_rel_ok;
    logic w_ovf_evt, w_len_evt;

    assign w_full     = (r_st[r_wb] != EMPTY);
    assign w_any_busy = (r_st[0] == BUSY) || (r_st[1] == BUSY);
    assign w_addr_ok  = ({1'b0, ext_addr} < P_LIM);
    assign w_wr_ok    = ext_we && !w_full && w_addr_ok;

    // A write landing in the same cycle as done counts toward completeness.
    assign w_mask_eff = w_mask[r_wb] | (w_wr_ok ? (P_CNT'(1) << ext_addr) : '0);
    assign w_need     = mode ? MASK_P : MASK_Q;
    assign w_done_try = ext_we_done && !w_full;
    assign w_fill_ok  = w_done_try && ((w_mask_eff & w_need) == w_need);
    assign w_fill_bad = w_done_try && ((w_mask_eff & w_need) != w_need);

    assign core_req   = (r_st[r_rb] == FULL) && !w_any_busy;
    assign core_mode  = r_mode[r_rb];
    assign w_ack_ok   = core_ack && core_req;
    assign w_rel_ok   = core_done && w_any_busy;

    assign w_ovf_evt  = (ext_we || ext_we_done) && w_full;
    assign w_len_evt  = (ext_we && !w_addr_ok) || w_fill_bad;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        lift_buf_bank #(.LANES(LANES), .CW(CW), .P_CNT(P_CNT), .AW(AW)) u_bank (
            .clk      (clk),
            .rst      (rst),
            .i_we     (w_wr_ok && (r_wb == 1'(g))),
            .i_waddr  (ext_addr),
            .i_wdat   (ext_din),
            .i_clr    ((w_rel_ok && (r_rb == 1'(g))) || (w_fill_bad && (r_wb == 1'(g)))),
            .i_rd_en  ((r_st[g] == BUSY) || (w_ack_ok && (r_rb == 1'(g)))),
            .i_raddr  (core_addr),
            .o_rd_dat (w_rd[g]),
            .o_mask   (w_mask[g])
        );
    end

    // The busy bank is always the one rb points at.
    assign core_dout = w_any_busy ? w_rd[r_rb] : '0;
    assign ext_full  = w_full;
    assign err_ovf   = r_err_ovf;
    assign err_len   = r_err_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st[0]   <= EMPTY;
            r_st[1]   <= EMPTY;
            r_mode    <= '0;
            r_wb      <= 1'b0;
            r_rb      <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_len <= 1'b0;
        end else begin
            if (w_fill_ok) begin
                r_st[r_wb]   <= FULL;
                r_mode[r_wb] <= mode;
                r_wb         <= ~r_wb;
            end
            if (w_ack_ok) begin
                r_st[r_rb] <= BUSY;
            end
            if (w_rel_ok) begin
                r_st[r_rb] <= EMPTY;
                r_rb       <= ~r_rb;
            end
            r_err_ovf <= err_clr ? 1'b0 : (r_err_ovf | w_ovf_evt);
            r_err_len <= err_clr ? 1'b0 : (r_err_len | w_len_evt);
        end
    end

`ifdef LIFT_BUF_CNT_EN
    logic [15:0] r_batch_cnt, r_drop_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_batch_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_rel_ok)  r_batch_cnt <= r_batch_cnt + 16'd1;
            if (w_ovf_evt) r_drop_cnt  <= r_drop_cnt + 16'd1;
        end
    end

    assign batch_cnt = r_batch_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_lift_pingpong_buf.sv
// Directed bench for lift_pingpong_buf: inputs change on the falling edge, outputs checked a cycle later.
module tb_lift_pingpong_buf;
    localparam int LANES = 8;
    localparam int CW    = 30;
    localparam int AW    = 4;
    localparam int DW    = LANES * CW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            mode = 1'b0;
    logic [AW-1:0]   ext_addr = '0;
    logic [DW-1:0]   ext_din = '0;
    logic            ext_we = 1'b0;
    logic            ext_we_done = 1'b0;
    logic            ext_full;
    logic            core_req;
    logic            core_mode;
    logic            core_ack = 1'b0;
    logic [AW-1:0]   core_addr = '0;
    logic [DW-1:0]   core_dout;
    logic            core_done = 1'b0;
    logic            err_ovf;
    logic            err_len;
    logic            err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW-1:0] data [7] = '{30'd370922924, 30'd422943464, 30'd164547197, 30'd814660070,
                                30'd705611185, 30'd887303870, 30'd123456789};
    logic [DW-1:0] exp_w;

    always #5 clk = ~clk;

    lift_pingpong_buf dut (
        .clk(clk), .rst(rst), .mode(mode), .ext_addr(ext_addr), .ext_din(ext_din),
        .ext_we(ext_we), .ext_we_done(ext_we_done), .ext_full(ext_full),
        .core_req(core_req), .core_mode(core_mode), .core_ack(core_ack),
        .core_addr(core_addr), .core_dout(core_dout), .core_done(core_done),
        .err_ovf(err_ovf), .err_len(err_len), .err_clr(err_clr)
    );

    task automatic reset_dut();
        rst = 1'b0; ext_we = 1'b0; ext_we_done = 1'b0; core_ack = 1'b0; core_done = 1'b0;
        err_clr = 1'b0; mode = 1'b0; core_addr = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [CW-1:0] v);
        ext_addr = a; ext_din = {LANES{v}}; ext_we = 1'b1;
        @(negedge clk);
        ext_we = 1'b0;
    endtask

    task automatic done(input logic m);
        mode = m; ext_we_done = 1'b1;
        @(negedge clk);
        ext_we_done = 1'b0;
    endtask

    task automatic fill(input logic m, input int n, input logic [CW-1:0] off);
        for (int i = 0; i < n; i++) wr(AW'(i), data[i] + off);
        done(m);
    endtask

    task automatic ack();
        core_ack = 1'b1;
        @(negedge clk);
        core_ack = 1'b0;
    endtask

    task automatic rel();
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        core_addr = a;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({ext_full, core_req, core_mode, err_ovf, err_len} !== 5'b0) begin
            $display("FAIL reset_flags got=%b exp=00000", {ext_full, core_req, core_mode, err_ovf, err_len}); n_fail++;
        end
        n_checks++;
        if (core_dout !== '0) begin $display("FAIL reset_dout got=%h exp=0", core_dout); n_fail++; end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        reset_dut();
        fill(1'b0, 6, '0);
        n_checks++;
        if ({core_req, core_mode, ext_full} !== 3'b100) begin
            $display("FAIL t1_offer got=%b exp=100", {core_req, core_mode, ext_full}); n_fail++;
        end
        core_addr = 4'd3;
        ack();
        exp_w = {LANES{30'd814660070}};
        n_checks++;
        if (core_dout !== exp_w) begin $display("FAIL t1_dout got=%h exp=%h", core_dout, exp_w); n_fail++; end
        n_checks++;
        if (core_req !== 1'b0) begin $display("FAIL t1_req_busy got=%b exp=0", core_req); n_fail++; end
        rel();
        n_checks++;
        if ({core_dout == '0, core_req, ext_full} !== 3'b100) begin
            $display("FAIL t1_release got=%b exp=100", {core_dout == '0, core_req, ext_full}); n_fail++;
        end
    endtask

    task automatic test_overflow();
        reset_dut();
        fill(1'b0, 6, '0);
        fill(1'b1, 7, 30'd100);
        n_checks++;
        if ({ext_full, core_req, err_ovf} !== 3'b110) begin
            $display("FAIL t2_full got=%b exp=110", {ext_full, core_req, err_ovf}); n_fail++;
        end
        rel();
        n_checks++;
        if ({ext_full, core_req, core_mode} !== 3'b110) begin
            $display("FAIL t2_stray_done got=%b exp=110", {ext_full, core_req, core_mode}); n_fail++;
        end
        wr(4'd0, 30'd5);
        n_checks++;
        if ({err_ovf, err_len} !== 2'b10) begin $display("FAIL t2_ovf got=%b exp=10", {err_ovf, err_len}); n_fail++; end
        core_addr = 4'd0;
        ack();
        exp_w = {LANES{30'd370922924}};
        n_checks++;
        if (core_dout !== exp_w) begin $display("FAIL t2_dout got=%h exp=%h", core_dout, exp_w); n_fail++; end
        err_clr = 1'b1; ext_we = 1'b1; ext_addr = 4'd1;
        @(negedge clk);
        err_clr = 1'b0; ext_we = 1'b0;
        n_checks++;
        if (err_ovf !== 1'b0) begin $display("FAIL t2_clr_prio got=%b exp=0", err_ovf); n_fail++; end
    endtask

    task automatic test_len();
        reset_dut();
        fill(1'b1, 6, '0);
        n_checks++;
        if ({err_len, core_req, ext_full} !== 3'b100) begin
            $display("FAIL t3_short got=%b exp=100", {err_len, core_req, ext_full}); n_fail++;
        end
        ack();
        n_checks++;
        if ({ext_full, core_dout == '0} !== 2'b01) begin
            $display("FAIL t3_stray_ack got=%b exp=01", {ext_full, core_dout == '0}); n_fail++;
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        wr(4'd7, 30'd9);
        n_checks++;
        if ({err_len, err_ovf} !== 2'b10) begin $display("FAIL t3_badaddr got=%b exp=10", {err_len, err_ovf}); n_fail++; end
        fill(1'b1, 7, '0);
        n_checks++;
        if ({core_req, core_mode} !== 2'b11) begin $display("FAIL t3_refill got=%b exp=11", {core_req, core_mode}); n_fail++; end
    endtask

    task automatic test_order();
        reset_dut();
        fill(1'b0, 6, '0);
        fill(1'b1, 7, 30'd1000);
        ack();
        rel();
        n_checks++;
        if ({core_req, core_mode, ext_full} !== 3'b110) begin
            $display("FAIL t4_next got=%b exp=110", {core_req, core_mode, ext_full}); n_fail++;
        end
        core_addr = 4'd6;
        ack();
        exp_w = {LANES{30'd123457789}};
        n_checks++;
        if (core_dout !== exp_w) begin $display("FAIL t4_dout6 got=%h exp=%h", core_dout, exp_w); n_fail++; end
        rd(4'd2);
        exp_w = {LANES{30'd164548197}};
        n_checks++;
        if (core_dout !== exp_w) begin $display("FAIL t4_dout2 got=%h exp=%h", core_dout, exp_w); n_fail++; end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        fill(1'b0, 6, '0);
        ack();
        fill(1'b1, 7, 30'd50);
        n_checks++;
        if (ext_full !== 1'b1) begin $display("FAIL t5_full got=%b exp=1", ext_full); n_fail++; end
        rel();
        ack();
        for (int i = 0; i < 5; i++) wr(AW'(i), data[i] + 30'd200);
        ext_addr = 4'd5; ext_din = {LANES{data[5] + 30'd200}}; ext_we = 1'b1;
        mode = 1'b0; ext_we_done = 1'b1; core_done = 1'b1;
        @(negedge clk);
        ext_we = 1'b0; ext_we_done = 1'b0; core_done = 1'b0;
        n_checks++;
        if ({core_req, core_mode, ext_full, err_len} !== 4'b1000) begin
            $display("FAIL t5_swap got=%b exp=1000", {core_req, core_mode, ext_full, err_len}); n_fail++;
        end
        core_addr = 4'd5;
        ack();
        exp_w = {LANES{30'd887304070}};
        n_checks++;
        if (core_dout !== exp_w) begin $display("FAIL t5_dout got=%h exp=%h", core_dout, exp_w); n_fail++; end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        fill(1'b0, 6, '0);
        core_addr = 4'd1;
        ack();
        exp_w = {LANES{30'd422943464}};
        n_checks++;
        if (core_dout !== exp_w) begin $display("FAIL t6_pre got=%h exp=%h", core_dout, exp_w); n_fail++; end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({core_dout == '0, core_req, ext_full} !== 3'b100) begin
            $display("FAIL t6_async got=%b exp=100", {core_dout == '0, core_req, ext_full}); n_fail++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill(1'b1, 7, 30'd7);
        n_checks++;
        if ({core_req, core_mode} !== 2'b11) begin $display("FAIL t6_fresh got=%b exp=11", {core_req, core_mode}); n_fail++; end
        core_addr = 4'd6;
        ack();
        exp_w = {LANES{30'd123456796}};
        n_checks++;
        if (core_dout !== exp_w) begin $display("FAIL t6_dout got=%h exp=%h", core_dout, exp_w); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_len();
        test_order();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lift_pingpong_buf.md
Name: lift_pingpong_buf

Overview:
Parametrised ping-pong input buffer that sits between the host coefficient port and the CRT lift datapath (q-basis to p-basis, Shoup-style).
- The host fills one bank with LANES-wide packed residue words while the lift core consumes the other bank.
- Succeeds the single-buffer ext_we/ext_we_done input scheme with explicit bank states, a core-side request/acknowledge handshake, per-batch mode and error reporting.
- Generalised over lane count, coefficient width and modulus counts.

Parameters:
LANES, 8, coefficients processed in parallel per word
CW, 30, residue width in bits
Q_CNT, 6, words per batch in mode 0 (small lift)
P_CNT, 7, words per batch in mode 1 (big lift); P_CNT >= Q_CNT
AW, 4, address width; 2**AW >= P_CNT

Ports:
clk  in  1  single clock
rst  in  1  reset; asynchronous, active-low
mode  in  1  batch mode; sampled with ext_we_done (0 = Q_CNT words, 1 = P_CNT words)
ext_addr  in  AW  host write address
ext_din  in  LANES*CW  host write word; lane k at bits [k*CW +: CW]
ext_we  in  1  host write strobe
ext_we_done  in  1  host batch-complete pulse
ext_full  out  1  fill bank not EMPTY; host must not write
core_req  out  1  a FULL bank is waiting and no bank is BUSY
core_mode  out  1  mode of the bank offered or held BUSY
core_ack  in  1  core accepts the offered bank
core_addr  in  AW  core read address
core_dout  out  LANES*CW  registered read data from the BUSY bank
core_done  in  1  core releases the BUSY bank
err_ovf  out  1  sticky: write or done dropped while ext_full
err_len  out  1  sticky: bad address, or incomplete batch at done
err_clr  in  1  clears both sticky flags

Behaviour:
- Reset values: all outputs 0, both banks EMPTY, valid masks 0, wb=rb=0. RAM contents are not cleared.
- Reset asserted mid-operation aborts everything immediately to the reset state.
- Bank state: 2 bits, EMPTY=0, FULL=1, BUSY=2. Each bank holds a P_CNT-bit word-valid mask and a stored mode bit.
- Fill pointer wb, read pointer rb. Banks are consumed strictly in fill order.
- ext_we with bank[wb]==EMPTY and ext_addr<P_CNT: write the word and set the mask bit.
- ext_we with ext_addr>=P_CNT: write dropped, err_len set.
- ext_we with ext_full=1: write dropped, err_ovf set.
- ext_we_done with ext_full=1: ignored, err_ovf set.
- ext_we_done, required mask present (low Q_CNT bits for mode 0, all P_CNT bits for mode 1): bank[wb] becomes FULL, mode stored, wb toggles; takes effect next cycle.
- ext_we_done, mask incomplete: err_len set, mask cleared, bank stays EMPTY, wb unchanged.
- ext_we and ext_we_done in the same cycle: the write applies first, then completeness is checked including that word.
- core_req = (bank[rb]==FULL) && no bank BUSY.
- core_mode = stored mode of bank[rb].
- core_ack while core_req=1: bank[rb] becomes BUSY. core_ack while core_req=0: ignored.
- core_dout: one-cycle latency from core_addr while a bank is BUSY; 0 when no bank is BUSY.
- core_done while a bank is BUSY: bank becomes EMPTY, mask cleared, rb toggles. core_done with no bank BUSY: ignored.
- ext_we_done and core_done on different banks in the same cycle: both apply.
- The bank freed by core_done becomes writable the next cycle (ext_full drops).
- err_clr has priority over a same-cycle set.

Optional Feature:
LIFT_BUF_CNT_EN
- Defined: adds outputs batch_cnt[15:0] (increments on each accepted core_done) and drop_cnt[15:0] (increments on each err_ovf event). Both wrap at 16 bits and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package lift_buf_pkg: bank-state constants EMPTY/FULL/BUSY; default CW/LANES/Q_CNT/P_CNT; required-mask helper function.
- Sub-module lift_buf_bank: one bank with P_CNT x LANES*CW storage, valid mask, write port, registered read port.
- Top instantiates two banks plus the state/pointer control.

Test Plan:
1. Mode 0; write addresses 0..5 with 8x{370922924, 422943464, 164547197, 814660070, 705611185, 887303870}; ext_we_done -> next cycle core_req=1, core_mode=0. core_ack, core_addr=3 -> core_dout = 8x814660070 one cycle later.
2. Fill bank0 (mode 0) and bank1 (mode 1, 7 words) with no ack -> ext_full=1. Extra write to addr 0 -> err_ovf=1; bank0 still reads back 8x370922924.
3. Mode 1, write only addresses 0..5, ext_we_done -> err_len=1, core_req stays 0, ext_full=0. Refilling with 7 words then succeeds.
4. Banks FULL in order bank0 (mode 0) then bank1 (mode 1). core_done on bank0 -> next cycle core_req=1 with core_mode=1; bank1 data reads back correctly.
5. Same-cycle core_done on bank1 and ext_we_done completing bank0 -> bank1 EMPTY, bank0 FULL, core_req=1 next cycle.
6. Assert rst low mid-read -> core_dout=0, core_req=0, ext_full=0 immediately. After release, a fresh batch is accepted.
